// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: shared constants and types for the stopwatch core.
//   SW_W                       default width of every count/load/lap field
//   SW_CS_MOD/SW_S_MOD/SW_M_MOD default moduli of the three counter stages
//   sw_time_t                  packed {m, s, cs} time value
//   sw_dir_e                   count direction (SW_UP / SW_DOWN)
package stopwatch_pkg;

  localparam int SW_W      = 7;
  localparam int SW_CS_MOD = 100;
  localparam int SW_S_MOD  = 60;
  localparam int SW_M_MOD  = 100;

  typedef struct packed {
    logic [SW_W-1:0] m;
    logic [SW_W-1:0] s;
    logic [SW_W-1:0] cs;
  } sw_time_t;

  typedef enum logic {
    SW_UP   = 1'b0,
    SW_DOWN = 1'b1
  } sw_dir_e;

endpackage

// File: rtl/sw_mod_cnt.sv
// sw_mod_cnt: modulo-MOD up/down counter stage with carry/borrow out.
// Ports:
//   clk, rst  clock, asynchronous active-high reset
//   clr       synchronous clear to 0
//   load      synchronous load of ld_val (clamped to MOD-1)
//   ld_val    preload value
//   en        advance one step in direction dir
//   dir       SW_UP / SW_DOWN
//   cnt       current count, 0..MOD-1
//   carry     en and the stage is at its terminal value (MOD-1 up, 0 down),
//             i.e. this step rolls over and the next stage must advance
module sw_mod_cnt
  import stopwatch_pkg::*;
#(
  parameter int MOD = 100,
  parameter int W   = SW_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] ld_val,
  input  logic         en,
  input  sw_dir_e      dir,
  output logic [W-1:0] cnt,
  output logic         carry
);

  localparam logic [W-1:0] MAXV = W'(MOD - 1);

  assign carry = en && ((dir == SW_UP) ? (cnt == MAXV) : (cnt == '0));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= (ld_val > MAXV) ? MAXV : ld_val;
    end else if (en) begin
      if (dir == SW_UP) begin
        cnt <= (cnt == MAXV) ? '0 : cnt + W'(1);
      end else begin
        cnt <= (cnt == '0) ? MAXV : cnt - W'(1);
      end
    end
  end

endmodule

// File: rtl/stopwatch_core.sv
// stopwatch_core: stopwatch/timer core. A run-gated prescaler produces a
// centisecond tick that advances a cs -> s -> m chain of modulo counters,
// counting up (with overflow wrap pulse) or down (with sticky expiry).
// Optional build macro: STOPWATCH_LAP_EN enables the lap capture registers;
// without it lap is ignored and lap_*/lap_valid are tied to 0.
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   run                  1 = prescaler advances, 0 = hold
//   clr                  synchronous clear of counts, prescaler and flags
//   load                 synchronous preload from ld_m/ld_s/ld_cs (clamped)
//   dir                  0 = up, 1 = down
//   ld_cs, ld_s, ld_m    preload fields
//   lap                  capture current count into lap_*
//   out_cs, out_s, out_m current count
//   tick                 one-cycle centisecond boundary pulse
//   wrap                 one-cycle pulse with the count after a full up overflow
//   expired              sticky: down count reached 0:0:0
//   lap_cs/lap_s/lap_m   captured count; lap_valid once any lap captured
module stopwatch_core
  import stopwatch_pkg::*;
#(
  parameter int TICK_DIV = 500000,
  parameter int CS_MOD   = SW_CS_MOD,
  parameter int S_MOD    = SW_S_MOD,
  parameter int M_MOD    = SW_M_MOD,
  parameter int W        = SW_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         run,
  input  logic         clr,
  input  logic         load,
  input  logic         dir,
  input  logic [W-1:0] ld_cs,
  input  logic [W-1:0] ld_s,
  input  logic [W-1:0] ld_m,
  input  logic         lap,
  output logic [W-1:0] out_cs,
  output logic [W-1:0] out_s,
  output logic [W-1:0] out_m,
  output logic         tick,
  output logic         wrap,
  output logic         expired,
  output logic [W-1:0] lap_cs,
  output logic [W-1:0] lap_s,
  output logic [W-1:0] lap_m,
  output logic         lap_valid
);

  localparam int            PW      = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);

  logic [PW-1:0] r_pre;
  logic          r_wrap;
  logic          r_expired;
  sw_dir_e       w_dir;
  logic          w_tick;
  logic          w_zero;
  logic          w_adv;
  logic          w_carry_cs;
  logic          w_carry_s;
  logic          w_carry_m;

  assign w_dir  = dir ? SW_DOWN : SW_UP;
  // Tick depends on the live run level so that dropping run in the terminal
  // prescaler cycle suppresses the tick.
  assign w_tick = run && (r_pre == PRE_MAX);
  assign w_zero = (out_cs == '0) && (out_s == '0) && (out_m == '0);
  // clr/load override the tick; a down tick at 0:0:0 is a no-op.
  assign w_adv  = w_tick && !clr && !load && !((w_dir == SW_DOWN) && w_zero);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pre <= '0;
    end else if (clr || load) begin
      r_pre <= '0;
    end else if (run) begin
      r_pre <= w_tick ? '0 : r_pre + PW'(1);
    end
  end

  sw_mod_cnt #(.MOD(CS_MOD), .W(W)) u_cs (
    .clk(clk), .rst(rst), .clr(clr), .load(load), .ld_val(ld_cs),
    .en(w_adv), .dir(w_dir), .cnt(out_cs), .carry(w_carry_cs)
  );

  // Each carry already includes the tick qualification of the stage below.
  sw_mod_cnt #(.MOD(S_MOD), .W(W)) u_s (
    .clk(clk), .rst(rst), .clr(clr), .load(load), .ld_val(ld_s),
    .en(w_carry_cs), .dir(w_dir), .cnt(out_s), .carry(w_carry_s)
  );

  sw_mod_cnt #(.MOD(M_MOD), .W(W)) u_m (
    .clk(clk), .rst(rst), .clr(clr), .load(load), .ld_val(ld_m),
    .en(w_carry_s), .dir(w_dir), .cnt(out_m), .carry(w_carry_m)
  );

  // Minutes carrying while counting up means the whole count rolled over.
  // w_carry_m is already gated off by clr/load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wrap <= 1'b0;
    end else begin
      r_wrap <= (w_dir == SW_UP) && w_carry_m;
    end
  end

  // Expiry fires on the down step out of 0:0:1; never touched while counting up.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_expired <= 1'b0;
    end else if (clr || load) begin
      r_expired <= 1'b0;
    end else if (w_adv && (w_dir == SW_DOWN) && (out_cs == W'(1)) &&
                 (out_s == '0) && (out_m == '0)) begin
      r_expired <= 1'b1;
    end
  end

  assign tick    = w_tick;
  assign wrap    = r_wrap;
  assign expired = r_expired;

`ifdef STOPWATCH_LAP_EN
  logic [W-1:0] r_lap_cs;
  logic [W-1:0] r_lap_s;
  logic [W-1:0] r_lap_m;
  logic         r_lap_valid;

  // Captures the count as seen this cycle, before any tick update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lap_cs    <= '0;
      r_lap_s     <= '0;
      r_lap_m     <= '0;
      r_lap_valid <= 1'b0;
    end else if (lap) begin
      r_lap_cs    <= out_cs;
      r_lap_s     <= out_s;
      r_lap_m     <= out_m;
      r_lap_valid <= 1'b1;
    end
  end

  assign lap_cs    = r_lap_cs;
  assign lap_s     = r_lap_s;
  assign lap_m     = r_lap_m;
  assign lap_valid = r_lap_valid;
`else
  logic w_unused_lap;
  assign w_unused_lap = lap;
  assign lap_cs    = '0;
  assign lap_s     = '0;
  assign lap_m     = '0;
  assign lap_valid = 1'b0;
`endif

endmodule

// File: tb/tb_stopwatch_core.sv
// tb_stopwatch_core: directed scenarios plus randomized stimulus against a
// reference model that keeps the time as a single centisecond total.
module tb_stopwatch_core;
  import stopwatch_pkg::*;

  localparam int TICK_DIV = 4;
  localparam int CS_MOD   = 100;
  localparam int S_MOD    = 60;
  localparam int M_MOD    = 100;
  localparam int W        = 7;
  localparam int TOTAL    = CS_MOD * S_MOD * M_MOD;
`ifdef STOPWATCH_LAP_EN
  localparam bit LAP_EN = 1'b1;
`else
  localparam bit LAP_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         run, clr, load, dir, lap;
  logic [W-1:0] ld_cs, ld_s, ld_m;
  logic [W-1:0] out_cs, out_s, out_m;
  logic         tick, wrap, expired;
  logic [W-1:0] lap_cs, lap_s, lap_m;
  logic         lap_valid;

  stopwatch_core #(
    .TICK_DIV(TICK_DIV), .CS_MOD(CS_MOD), .S_MOD(S_MOD), .M_MOD(M_MOD), .W(W)
  ) dut (
    .clk(clk), .rst(rst), .run(run), .clr(clr), .load(load), .dir(dir),
    .ld_cs(ld_cs), .ld_s(ld_s), .ld_m(ld_m), .lap(lap),
    .out_cs(out_cs), .out_s(out_s), .out_m(out_m),
    .tick(tick), .wrap(wrap), .expired(expired),
    .lap_cs(lap_cs), .lap_s(lap_s), .lap_m(lap_m), .lap_valid(lap_valid)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int tick_seen = 0;
  int wrap_seen = 0;
  int last_tick_cyc = -1;

  // Reference model state: time as total centiseconds.
  int m_t, m_pre, m_lap_t;
  bit m_exp, m_wrap, m_lap_v;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic sw_time_t to_time(input int t);
    sw_time_t r;
    r.m  = W'(t / (CS_MOD * S_MOD));
    r.s  = W'((t / CS_MOD) % S_MOD);
    r.cs = W'(t % CS_MOD);
    return r;
  endfunction

  function automatic int clampf(input int v, input int md);
    return (v >= md) ? md - 1 : v;
  endfunction

  task automatic model_reset();
    m_t = 0; m_pre = 0; m_exp = 0; m_wrap = 0; m_lap_t = 0; m_lap_v = 0;
  endtask

  task automatic model_step();
    int  old_t;
    bit  tk;
    old_t  = m_t;
    tk     = run && (m_pre == TICK_DIV - 1);
    m_wrap = 0;
    if (clr) begin
      m_t = 0; m_pre = 0; m_exp = 0;
    end else if (load) begin
      m_t = clampf(int'(ld_m), M_MOD) * CS_MOD * S_MOD +
            clampf(int'(ld_s), S_MOD) * CS_MOD + clampf(int'(ld_cs), CS_MOD);
      m_pre = 0; m_exp = 0;
    end else begin
      if (run) m_pre = tk ? 0 : m_pre + 1;
      if (tk) begin
        if (!dir) begin
          if (m_t == TOTAL - 1) begin m_t = 0; m_wrap = 1; end
          else m_t = m_t + 1;
        end else if (m_t > 0) begin
          m_t = m_t - 1;
          if (m_t == 0) m_exp = 1;
        end
      end
    end
    if (LAP_EN && lap) begin
      m_lap_t = old_t; m_lap_v = 1;
    end
  endtask

  task automatic check_all(input string tag);
    sw_time_t e, l;
    e = to_time(m_t);
    l = to_time(m_lap_t);
    chk({tag, ".cs"}, 32'(out_cs), 32'(e.cs));
    chk({tag, ".s"},  32'(out_s),  32'(e.s));
    chk({tag, ".m"},  32'(out_m),  32'(e.m));
    chk({tag, ".tick"}, 32'(tick), 32'(run && (m_pre == TICK_DIV - 1)));
    chk({tag, ".wrap"}, 32'(wrap), 32'(m_wrap));
    chk({tag, ".expired"}, 32'(expired), 32'(m_exp));
    chk({tag, ".lap_cs"}, 32'(lap_cs), 32'(l.cs));
    chk({tag, ".lap_s"},  32'(lap_s),  32'(l.s));
    chk({tag, ".lap_m"},  32'(lap_m),  32'(l.m));
    chk({tag, ".lap_valid"}, 32'(lap_valid), 32'(m_lap_v));
  endtask

  // Entered just after a negedge with inputs applied; returns at the next negedge.
  task automatic cycle(input string tag);
    #1;
    check_all(tag);
    if (tick === 1'b1) begin tick_seen++; last_tick_cyc = cyc; end
    if (wrap === 1'b1) wrap_seen++;
    @(posedge clk);
    model_step();
    cyc++;
    @(negedge clk);
  endtask

  task automatic cycles(input string tag, input int n);
    for (int i = 0; i < n; i++) cycle(tag);
  endtask

  task automatic do_load(input string tag, input int m, input int s, input int cs);
    ld_m = W'(m); ld_s = W'(s); ld_cs = W'(cs);
    load = 1'b1;
    cycle(tag);
    load = 1'b0;
  endtask

  initial begin
    rst = 1'b1; run = 0; clr = 0; load = 0; dir = 0; lap = 0;
    ld_cs = '0; ld_s = '0; ld_m = '0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset state
    cycle("reset");

    // 1: 400 running cycles from reset -> 100 ticks, 0:01:00
    tick_seen = 0;
    run = 1; dir = 0;
    cycles("t1", 400);
    chk("t1.ticks", 32'(tick_seen), 32'd100);
    chk("t1.s", 32'(out_s), 32'd1);
    chk("t1.cs", 32'(out_cs), 32'd0);

    // 2: up-count overflow from 99:59:98
    run = 0;
    do_load("t2.load", 99, 59, 98);
    wrap_seen = 0;
    run = 1;
    cycles("t2", 8);
    run = 0;
    cycles("t2.post", 2);
    chk("t2.wraps", 32'(wrap_seen), 32'd1);
    chk("t2.m", 32'(out_m), 32'd0);
    chk("t2.expired", 32'(expired), 32'd0);

    // 3: down count to expiry, hold, load clears expiry
    dir = 1;
    do_load("t3.load", 0, 0, 2);
    run = 1;
    cycles("t3", 16);
    chk("t3.expired", 32'(expired), 32'd1);
    chk("t3.cs", 32'(out_cs), 32'd0);
    cycles("t3.hold", 12);
    chk("t3.hold_exp", 32'(expired), 32'd1);
    run = 0;
    do_load("t3.reload", 0, 0, 5);
    chk("t3.cleared", 32'(expired), 32'd0);

    // 4: run gating resumes mid-period
    clr = 1; cycle("t4.clr"); clr = 0;
    tick_seen = 0;
    run = 1; cycles("t4.a", 2);
    run = 0; cycles("t4.b", 10);
    run = 1; cycles("t4.c", 2);
    chk("t4.ticks", 32'(tick_seen), 32'd1);
    chk("t4.when", 32'(last_tick_cyc), 32'(cyc - 1));

    // 5: clr in a tick cycle at 0:05:10, then asynchronous reset mid-run
    run = 0; dir = 0;
    do_load("t5.load", 0, 5, 10);
    run = 1;
    cycles("t5.run", 3);
    clr = 1;
    cycle("t5.clr");
    clr = 0;
    chk("t5.cs", 32'(out_cs), 32'd0);
    chk("t5.s", 32'(out_s), 32'd0);
    cycles("t5.more", 9);
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk("t5.rst_cs", 32'(out_cs), 32'd0);
    chk("t5.rst_s", 32'(out_s), 32'd0);
    chk("t5.rst_tick", 32'(tick), 32'd0);
    rst = 1'b0;
    #1;
    cycle("t5.after_rst");

    // 6: lap capture at 0:03:07 while running
    run = 0;
    do_load("t6.load", 0, 3, 7);
    run = 1; lap = 1;
    cycle("t6.lap");
    lap = 0;
    cycles("t6.run", 5);
    chk("t6.lap_s", 32'(lap_s), LAP_EN ? 32'd3 : 32'd0);
    chk("t6.lap_cs", 32'(lap_cs), LAP_EN ? 32'd7 : 32'd0);
    chk("t6.lap_valid", 32'(lap_valid), LAP_EN ? 32'd1 : 32'd0);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      run  = ($urandom_range(0, 9) < 8);
      clr  = ($urandom_range(0, 199) == 0);
      load = ($urandom_range(0, 59) == 0);
      lap  = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 49) == 0) dir = ~dir;
      if ($urandom_range(0, 1) == 0) begin
        ld_m = W'($urandom_range(0, 127)); ld_s = W'($urandom_range(0, 127));
        ld_cs = W'($urandom_range(0, 127));
      end else if (dir) begin
        ld_m = '0; ld_s = W'($urandom_range(0, 1)); ld_cs = W'($urandom_range(0, 3));
      end else begin
        ld_m = W'(99); ld_s = W'(59); ld_cs = W'($urandom_range(96, 99));
      end
      cycle("rand");
    end
    run = 0; clr = 0; load = 0; lap = 0;
    cycle("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
